// File: rtl/exe_stage.sv
`default_nettype none
// ============================================================================
//  Module      : exe_stage (with local helper module alu)
//  Description : Execute stage of the five-stage LoongArch pipeline. Holds one
//                instruction in a valid-tagged pipeline register, selects the
//                ALU operands and issues the word-sized data-SRAM request for
//                loads and stores. It forwards the result to the memory stage
//                and drives a bypass bus back to decode.
//
//  Ports       : clk, reset         - clock, synchronous active-high reset
//                ms_allowin         - memory stage can accept this cycle
//                ds_to_es_valid/bus - instruction from decode (150 bits)
//                es_allowin         - stage can accept from decode
//                es_to_ms_valid/bus - instruction to memory (71 bits)
//                es_fwd_bus         - {load_block, fwd_we, fwd_dest, fwd_data}
//                data_sram_*        - data-SRAM request (en, we, addr, wdata)
//
//  Options     : ES_FWD_DATA_EN - when defined, fwd_data carries alu_result.
//                Otherwise fwd_data is zero and decode must stall on every
//                EXE hazard.
//
//  Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  alu : combinational 32-bit ALU, 12-bit one-hot operation select
//  op bit: 0 add, 1 sub, 2 slt, 3 sltu, 4 and, 5 nor, 6 or, 7 xor,
//          8 sll, 9 srl, 10 sra, 11 lui (passes src2)
// ----------------------------------------------------------------------------
module alu (
    input  logic [11:0] i_alu_op,
    input  logic [31:0] i_alu_src1,
    input  logic [31:0] i_alu_src2,
    output logic [31:0] o_alu_result
);
    logic w_op_add, w_op_sub, w_op_slt, w_op_sltu;
    logic w_op_and, w_op_nor, w_op_or,  w_op_xor;
    logic w_op_sll, w_op_srl, w_op_sra, w_op_lui;

    assign w_op_add  = i_alu_op[0];
    assign w_op_sub  = i_alu_op[1];
    assign w_op_slt  = i_alu_op[2];
    assign w_op_sltu = i_alu_op[3];
    assign w_op_and  = i_alu_op[4];
    assign w_op_nor  = i_alu_op[5];
    assign w_op_or   = i_alu_op[6];
    assign w_op_xor  = i_alu_op[7];
    assign w_op_sll  = i_alu_op[8];
    assign w_op_srl  = i_alu_op[9];
    assign w_op_sra  = i_alu_op[10];
    assign w_op_lui  = i_alu_op[11];

    // One shared adder: subtraction and both compares use a + ~b + 1.
    logic        w_use_sub;
    logic [31:0] w_adder_b;
    logic [31:0] w_adder_sum;
    logic        w_adder_cout;
    logic        w_slt;
    logic        w_sltu;
    logic [31:0] w_sra;

    assign w_use_sub = w_op_sub | w_op_slt | w_op_sltu;
    assign w_adder_b = w_use_sub ? ~i_alu_src2 : i_alu_src2;
    assign {w_adder_cout, w_adder_sum} = {1'b0, i_alu_src1} + {1'b0, w_adder_b}
                                       + {32'b0, w_use_sub};

    // Signed less-than: differing signs decide directly, else the difference sign.
    assign w_slt  = (i_alu_src1[31] & ~i_alu_src2[31])
                  | (~(i_alu_src1[31] ^ i_alu_src2[31]) & w_adder_sum[31]);
    // Unsigned less-than: no carry out of a + ~b + 1 means a borrow occurred.
    assign w_sltu = ~w_adder_cout;
    assign w_sra  = $signed(i_alu_src1) >>> i_alu_src2[4:0];

    assign o_alu_result = ({32{w_op_add | w_op_sub}} & w_adder_sum)
                        | ({32{w_op_slt}}  & {31'b0, w_slt})
                        | ({32{w_op_sltu}} & {31'b0, w_sltu})
                        | ({32{w_op_and}}  & (i_alu_src1 & i_alu_src2))
                        | ({32{w_op_nor}}  & ~(i_alu_src1 | i_alu_src2))
                        | ({32{w_op_or}}   & (i_alu_src1 | i_alu_src2))
                        | ({32{w_op_xor}}  & (i_alu_src1 ^ i_alu_src2))
                        | ({32{w_op_sll}}  & (i_alu_src1 << i_alu_src2[4:0]))
                        | ({32{w_op_srl}}  & (i_alu_src1 >> i_alu_src2[4:0]))
                        | ({32{w_op_sra}}  & w_sra)
                        | ({32{w_op_lui}}  & i_alu_src2);
endmodule

// ----------------------------------------------------------------------------
//  exe_stage
// ----------------------------------------------------------------------------
module exe_stage (
    input  logic         clk,
    input  logic         reset,
    input  logic         ms_allowin,
    input  logic         ds_to_es_valid,
    input  logic [149:0] ds_to_es_bus,
    output logic         es_allowin,
    output logic         es_to_ms_valid,
    output logic [70:0]  es_to_ms_bus,
    output logic [38:0]  es_fwd_bus,
    output logic         data_sram_en,
    output logic [3:0]   data_sram_we,
    output logic [31:0]  data_sram_addr,
    output logic [31:0]  data_sram_wdata
);
    // Single-cycle stage: the result is always ready in the cycle it is held.
    localparam logic c_ES_READY_GO = 1'b1;

    logic         r_es_valid;
    logic [149:0] r_ds_to_es_bus;

    // Decoded fields of the held instruction
    logic [11:0] w_alu_op;
    logic        w_load_op;
    logic        w_src1_is_pc;
    logic        w_src2_is_imm;
    logic        w_gr_we;
    logic        w_mem_we;
    logic [4:0]  w_dest;
    logic [31:0] w_imm;
    logic [31:0] w_rj_value;
    logic [31:0] w_rkd_value;
    logic [31:0] w_pc;

    assign {w_alu_op, w_load_op, w_src1_is_pc, w_src2_is_imm, w_gr_we, w_mem_we,
            w_dest, w_imm, w_rj_value, w_rkd_value, w_pc} = r_ds_to_es_bus;

    // ---------------- handshake ----------------
    assign es_allowin     = !r_es_valid || (c_ES_READY_GO && ms_allowin);
    assign es_to_ms_valid = r_es_valid && c_ES_READY_GO;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_es_valid <= 1'b0;
        end else if (es_allowin) begin
            r_es_valid <= ds_to_es_valid;
        end
    end

    // Payload needs no reset: it is only ever observed qualified by r_es_valid.
    always_ff @(posedge clk) begin
        if (ds_to_es_valid && es_allowin) begin
            r_ds_to_es_bus <= ds_to_es_bus;
        end
    end

    // ---------------- ALU ----------------
    logic [31:0] w_alu_src1;
    logic [31:0] w_alu_src2;
    logic [31:0] w_alu_result;

    assign w_alu_src1 = w_src1_is_pc  ? w_pc  : w_rj_value;
    assign w_alu_src2 = w_src2_is_imm ? w_imm : w_rkd_value;

    alu u_alu (
        .i_alu_op     (w_alu_op),
        .i_alu_src1   (w_alu_src1),
        .i_alu_src2   (w_alu_src2),
        .o_alu_result (w_alu_result)
    );

    assign es_to_ms_bus = {w_load_op, w_gr_we, w_dest, w_alu_result, w_pc};

    // ---------------- data SRAM request ----------------
    // Gating with ms_allowin makes the request fire only in the cycle the
    // instruction advances, so a stalled store is never issued twice.
    assign data_sram_en    = r_es_valid && ms_allowin && (w_load_op || w_mem_we);
    assign data_sram_we    = {4{data_sram_en && w_mem_we}};
    assign data_sram_addr  = w_alu_result;
    assign data_sram_wdata = w_rkd_value;

    // ---------------- bypass bus to decode ----------------
    logic        w_fwd_we;
    logic        w_load_block;
    logic [31:0] w_fwd_data;

    // r0 is hardwired to zero, so writes to it never create a hazard.
    assign w_fwd_we     = r_es_valid && w_gr_we && (w_dest != 5'd0);
    assign w_load_block = w_fwd_we && w_load_op;

`ifdef ES_FWD_DATA_EN
    assign w_fwd_data = w_alu_result;
`else
    assign w_fwd_data = 32'b0;
`endif

    assign es_fwd_bus = {w_load_block, w_fwd_we, w_dest, w_fwd_data};

endmodule
`default_nettype wire

// File: tb/tb_exe_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exe_stage
//  Description : Directed self-checking bench for exe_stage. Inputs change on
//                the falling edge; outputs are sampled on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_exe_stage;
    localparam logic [11:0] c_OP_ADD  = 12'h001;
    localparam logic [11:0] c_OP_SUB  = 12'h002;
    localparam logic [11:0] c_OP_SLT  = 12'h004;
    localparam logic [11:0] c_OP_SLTU = 12'h008;
    localparam logic [11:0] c_OP_NOR  = 12'h020;
    localparam logic [11:0] c_OP_SRA  = 12'h400;

    logic         clk;
    logic         reset;
    logic         ms_allowin;
    logic         ds_to_es_valid;
    logic [149:0] ds_to_es_bus;
    logic         es_allowin;
    logic         es_to_ms_valid;
    logic [70:0]  es_to_ms_bus;
    logic [38:0]  es_fwd_bus;
    logic         data_sram_en;
    logic [3:0]   data_sram_we;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;

    int n_checks = 0;
    int n_pass   = 0;

    exe_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ms_allowin      (ms_allowin),
        .ds_to_es_valid  (ds_to_es_valid),
        .ds_to_es_bus    (ds_to_es_bus),
        .es_allowin      (es_allowin),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .es_fwd_bus      (es_fwd_bus),
        .data_sram_en    (data_sram_en),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [149:0] make_bus(
        input logic [11:0] op,   input logic ld,     input logic s1pc,
        input logic s2imm,       input logic grwe,   input logic memwe,
        input logic [4:0] dest,  input logic [31:0] imm,
        input logic [31:0] rj,   input logic [31:0] rkd, input logic [31:0] pc);
        return {op, ld, s1pc, s2imm, grwe, memwe, dest, imm, rj, rkd, pc};
    endfunction

    logic [31:0] exp_fwd_add;
    logic [31:0] vec_a   [4];
    logic [31:0] vec_b   [4];
    logic [11:0] vec_op  [4];
    logic [31:0] vec_exp [4];

    initial begin
`ifdef ES_FWD_DATA_EN
        exp_fwd_add = 32'h0000000C;
`else
        exp_fwd_add = 32'h00000000;
`endif
        vec_op[0] = c_OP_SLTU; vec_a[0] = 32'hFFFFFFFF; vec_b[0] = 32'h1; vec_exp[0] = 32'h0;
        vec_op[1] = c_OP_SLT;  vec_a[1] = 32'hFFFFFFFF; vec_b[1] = 32'h1; vec_exp[1] = 32'h1;
        vec_op[2] = c_OP_SRA;  vec_a[2] = 32'h80000000; vec_b[2] = 32'h4; vec_exp[2] = 32'hF8000000;
        vec_op[3] = c_OP_NOR;  vec_a[3] = 32'h0;        vec_b[3] = 32'h0; vec_exp[3] = 32'hFFFFFFFF;

        // ---- reset held 3 cycles with a valid instruction offered ----
        reset          = 1'b1;
        ms_allowin     = 1'b1;
        ds_to_es_valid = 1'b1;
        ds_to_es_bus   = make_bus(c_OP_ADD, 0, 0, 0, 1, 0, 5'd3, 32'h0, 32'd5, 32'd7, 32'h1C000000);
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_valid",   64'(es_to_ms_valid), 64'h0);
            check("rst_allowin", 64'(es_allowin),     64'h1);
            check("rst_en",      64'(data_sram_en),   64'h0);
            check("rst_fwd",     64'(es_fwd_bus[38:37]), 64'h0);
        end
        reset = 1'b0;

        // ---- add then sub, back to back ----
        step();
        check("add_valid",  64'(es_to_ms_valid),       64'h1);
        check("add_result", 64'(es_to_ms_bus[63:32]),  64'h0000000C);
        check("add_dest",   64'(es_to_ms_bus[68:64]),  64'h3);
        check("add_fwd_we", 64'(es_fwd_bus[37]),       64'h1);
        check("add_fwd_dest", 64'(es_fwd_bus[36:32]),  64'h3);
        check("add_fwd_data", 64'(es_fwd_bus[31:0]),   64'(exp_fwd_add));
        check("add_en",     64'(data_sram_en),         64'h0);
        ds_to_es_bus = make_bus(c_OP_SUB, 0, 0, 0, 1, 0, 5'd3, 32'h0, 32'd5, 32'd7, 32'h1C000004);
        step();
        check("sub_valid",  64'(es_to_ms_valid),       64'h1);
        check("sub_result", 64'(es_to_ms_bus[63:32]),  64'hFFFFFFFE);

        // ---- pc + imm ----
        ds_to_es_bus = make_bus(c_OP_ADD, 0, 1, 1, 1, 0, 5'd6, 32'h8, 32'h55, 32'h66, 32'h1C000010);
        step();
        check("pcimm_result", 64'(es_to_ms_bus[63:32]), 64'h1C000018);
        check("pcimm_pc",     64'(es_to_ms_bus[31:0]),  64'h1C000010);

        // ---- small ALU operation table ----
        for (int i = 0; i < 4; i++) begin
            ds_to_es_bus = make_bus(vec_op[i], 0, 0, 0, 1, 0, 5'd7, 32'h0, vec_a[i], vec_b[i], 32'h1C000020);
            step();
            check("alu_vec", 64'(es_to_ms_bus[63:32]), 64'(vec_exp[i]));
        end

        // ---- store held by a 2-cycle stall ----
        ds_to_es_bus = make_bus(c_OP_ADD, 0, 0, 1, 0, 1, 5'd0, 32'h4, 32'h100, 32'hDEADBEEF, 32'h1C000030);
        step();
        ms_allowin     = 1'b0;
        ds_to_es_valid = 1'b0;
        ds_to_es_bus   = make_bus(c_OP_SUB, 0, 0, 0, 1, 0, 5'd9, 32'h0, 32'h1, 32'h1, 32'h0);
        for (int i = 0; i < 2; i++) begin
            #1;
            check("st_stall_en",      64'(data_sram_en),    64'h0);
            check("st_stall_allowin", 64'(es_allowin),      64'h0);
            check("st_stall_addr",    64'(data_sram_addr),  64'h104);
            check("st_stall_valid",   64'(es_to_ms_valid),  64'h1);
            step();
        end
        ms_allowin = 1'b1;
        #1;
        check("st_en",    64'(data_sram_en),    64'h1);
        check("st_we",    64'(data_sram_we),    64'hF);
        check("st_addr",  64'(data_sram_addr),  64'h104);
        check("st_wdata", 64'(data_sram_wdata), 64'hDEADBEEF);
        check("st_res_from_mem", 64'(es_to_ms_bus[70]), 64'h0);
        step();
        // Bubble follows: the store must not be issued again.
        check("bubble_valid",   64'(es_to_ms_valid), 64'h0);
        check("bubble_en",      64'(data_sram_en),   64'h0);
        check("bubble_we",      64'(data_sram_we),   64'h0);
        check("bubble_allowin", 64'(es_allowin),     64'h1);

        // ---- load bypass ----
        ds_to_es_valid = 1'b1;
        ds_to_es_bus   = make_bus(c_OP_ADD, 1, 0, 1, 1, 0, 5'd4, 32'h0, 32'h200, 32'h0, 32'h1C000040);
        step();
        check("ld_block",        64'(es_fwd_bus[38]),    64'h1);
        check("ld_fwd_we",       64'(es_fwd_bus[37]),    64'h1);
        check("ld_fwd_dest",     64'(es_fwd_bus[36:32]), 64'h4);
        check("ld_res_from_mem", 64'(es_to_ms_bus[70]),  64'h1);
        check("ld_en",           64'(data_sram_en),      64'h1);
        check("ld_we",           64'(data_sram_we),      64'h0);
        check("ld_addr",         64'(data_sram_addr),    64'h200);
        ds_to_es_bus = make_bus(c_OP_ADD, 1, 0, 1, 1, 0, 5'd0, 32'h0, 32'h200, 32'h0, 32'h1C000044);
        step();
        check("ld_r0_fwd_we", 64'(es_fwd_bus[37]), 64'h0);
        check("ld_r0_block",  64'(es_fwd_bus[38]), 64'h0);

        // ---- reset in the middle of a stall ----
        ms_allowin   = 1'b0;
        ds_to_es_bus = make_bus(c_OP_ADD, 0, 0, 0, 1, 0, 5'd3, 32'h0, 32'd1, 32'd2, 32'h0);
        #1;
        check("stall_allowin", 64'(es_allowin), 64'h0);
        check("stall_fwd_dest", 64'(es_fwd_bus[36:32]), 64'h0);
        reset = 1'b1;
        step();
        check("midrst_valid",   64'(es_to_ms_valid), 64'h0);
        check("midrst_allowin", 64'(es_allowin),     64'h1);
        reset          = 1'b0;
        ds_to_es_valid = 1'b0;
        ms_allowin     = 1'b1;
        step();
        check("post_rst_bubble", 64'(es_to_ms_valid), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/exe_stage.md
# exe_stage

Execute stage of the five-stage LoongArch pipeline, between the decode stage and the memory stage. It holds one instruction in a valid-tagged pipeline register and selects the ALU operands. The 12-bit one-hot ALU operation is passed straight to the `alu` block. The stage issues the data-SRAM request for loads and stores and forwards the result to the memory stage. A bypass bus back to decode supports hazard handling.

## Interface
- No parameters.
- `clk` in 1: pipeline clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `ms_allowin` in 1: memory stage can accept an instruction this cycle.
- `ds_to_es_valid` in 1: decode presents a valid instruction.
- `ds_to_es_bus` in 150: {alu_op[149:138], load_op[137], src1_is_pc[136], src2_is_imm[135], gr_we[134], mem_we[133], dest[132:128], imm[127:96], rj_value[95:64], rkd_value[63:32], pc[31:0]}.
- `es_allowin` out 1: stage can accept from decode.
- `es_to_ms_valid` out 1: stage presents a valid instruction to memory.
- `es_to_ms_bus` out 71: {res_from_mem[70], gr_we[69], dest[68:64], alu_result[63:32], pc[31:0]}.
- `es_fwd_bus` out 39: {load_block[38], fwd_we[37], fwd_dest[36:32], fwd_data[31:0]}.
- `data_sram_en` out 1: data-SRAM request strobe.
- `data_sram_we` out 4: byte write enables.
- `data_sram_addr` out 32: byte address.
- `data_sram_wdata` out 32: store data.

## Operation
- Register state:
  - `es_valid`, 1 bit.
  - `ds_to_es_bus_r`, 150 bits.
- Handshake:
  - `es_ready_go = 1`, because the stage is single-cycle.
  - `es_allowin = !es_valid || (es_ready_go && ms_allowin)`.
  - `es_to_ms_valid = es_valid && es_ready_go`.
- Valid update: when `es_allowin` is 1, `es_valid <= ds_to_es_valid`. Otherwise it holds.
- Bus capture: `ds_to_es_bus_r` loads only when `ds_to_es_valid && es_allowin`. Otherwise it holds, including while stalled by `ms_allowin = 0`.
- Operand selection:
  - `alu_src1 = src1_is_pc ? pc : rj_value`.
  - `alu_src2 = src2_is_imm ? imm : rkd_value`.
  - `alu_op` goes unmodified to one `alu` instance.
- Output bus: `res_from_mem = load_op`. `gr_we`, `dest` and `pc` are copied from the register.
- Memory request:
  - `data_sram_en = es_valid && ms_allowin && (load_op || mem_we)`. The request fires exactly once, in the cycle the instruction advances.
  - `data_sram_we = {4{data_sram_en && mem_we}}`.
  - `data_sram_addr = alu_result`.
  - `data_sram_wdata = rkd_value`.
  - Only word access is supported; there is no alignment check.
- Bypass bus:
  - `fwd_we = es_valid && gr_we && (dest != 0)`.
  - `fwd_dest = dest`.
  - `load_block = fwd_we && load_op`.
  - `fwd_data` is described under Configuration.
- Reset:
  - `es_valid = 0`.
  - All outputs gated by `es_valid` read 0: `es_to_ms_valid`, `data_sram_en`, `data_sram_we`, `fwd_we` and `load_block`.
  - `es_allowin = 1`.
  - `ds_to_es_bus_r` is not reset.
  - A reset in the middle of a stall discards the held instruction.

## Timing
- Latency: 1 cycle from decode capture to `es_to_ms_valid`, because the ALU is combinational.
- Accept and drain in the same cycle: with `es_valid = 1` and `ms_allowin = 1`, a new instruction is captured in the cycle the old one leaves. Throughput is 1 instruction per cycle.
- Stall: with `ms_allowin = 0` and `es_valid = 1`:
  - `es_allowin = 0`.
  - The register and outputs stay stable.
  - `data_sram_en = 0`.
  - `es_fwd_bus` continues to present the held instruction.
- Bubble: `ds_to_es_valid = 0` while `es_allowin = 1` clears `es_valid` at the next edge.
- All outputs are combinational from the registers plus `ms_allowin`. No output depends combinationally on `ds_to_es_*`.

## Configuration
- `ES_FWD_DATA_EN`: when defined, `fwd_data = alu_result`, so decode can bypass EXE results.
- When not defined:
  - `fwd_data = 32'b0`.
  - `fwd_we` and `load_block` still behave as above, and decode resolves every EXE hazard by stalling.
  - Port widths do not change.

## Test plan
- **Reset.** Hold `reset` for 3 cycles with `ds_to_es_valid = 1`. Required: `es_to_ms_valid = 0`, `es_allowin = 1`, `data_sram_en = 0`, `es_fwd_bus[38:37] = 0`. On the first cycle after reset the instruction is captured.
- **Add, back to back.** Send `alu_op = 12'h001`, rj = 5, rk = 7, dest = 3, then `alu_op = 12'h002` (sub), rj = 5, rk = 7, with `ms_allowin = 1`. Required: consecutive cycles show `alu_result = 32'h0000000C`, then `32'hFFFFFFFE`, with `es_to_ms_valid` high both cycles.
- **PC + immediate.** Send `src1_is_pc = 1`, `src2_is_imm = 1`, pc = `32'h1C000010`, imm = `32'h00000008`, op add. Required: `alu_result = 32'h1C000018`.
- **Store under stall.** Send `mem_we = 1`, rj = `32'h100`, imm = 4, rkd = `32'hDEADBEEF`, with `ms_allowin = 0` for 2 cycles, then 1. Required:
  - `data_sram_en = 0` while stalled.
  - Then exactly one cycle with en = 1, we = `4'hF`, addr = `32'h104`, wdata = `32'hDEADBEEF`.
  - `es_allowin = 0` throughout the stall.
- **Load bypass.** Send `load_op = 1`, `gr_we = 1`, dest = 4. Required: `load_block = 1`, `fwd_dest = 4`, `res_from_mem = 1`. With dest = 0: `fwd_we = 0`.
- **Configuration.** Repeat the add test with and without `ES_FWD_DATA_EN`. Required: `fwd_data = 32'h0000000C` with the macro, and 0 without it.
